mem_bus_scheduler: RTL and testbench

MEM_BUS_SCHEDULER -- requirements
Module: mem_bus_scheduler

---
 rtl/mem_bus_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_mem_bus_scheduler.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_bus_scheduler
// Purpose  : Arbitrates a single memory master port between an instruction
//            cache and a data cache. The data cache wins ties. An optional
//            starvation guard periodically hands a tie to the instruction
//            cache. Ownership is held for the whole transaction. Every
//            completion or abort passes through one IDLE arbitration cycle.
// Revision : 1.0 - initial release
//
// Configuration macro:
//   MEM_BUS_SCHEDULER_ANTI_STARVE_EN - when defined, a saturating counter
//            tracks dcache grants made while icache is waiting. When the
//            counter reaches STARVE_LIMIT, a tie goes to icache. When the
//            macro is undefined, dcache has strict priority on ties.
//
// Parameters:
//   ADDR_W       - address width
//   DATA_W       - data width
//   STARVE_LIMIT - consecutive dcache grants tolerated while icache waits (>=1)
//
// Ports:
//   clk_i, reset_n_i             - rising-edge clock, async active-low reset
//   icache_{addr,wr_data,write,valid}_i / icache_{rd_data,ready}_o
//                                - instruction cache slave port
//   dcache_{addr,wr_data,write,valid}_i / dcache_{rd_data,ready}_o
//                                - data cache slave port
//   mem_{addr,wr_data,write,valid}_o / mem_{rd_data,ready}_i
//                                - memory master port
//   owner_o                      - 00 none, 01 icache, 10 dcache (registered)
// ============================================================================
module mem_bus_scheduler #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    // icache slave
    input  logic [ADDR_W-1:0] icache_addr_i,
    input  logic [DATA_W-1:0] icache_wr_data_i,
    input  logic              icache_write_i,
    input  logic              icache_valid_i,
    output logic [DATA_W-1:0] icache_rd_data_o,
    output logic              icache_ready_o,
    // dcache slave
    input  logic [ADDR_W-1:0] dcache_addr_i,
    input  logic [DATA_W-1:0] dcache_wr_data_i,
    input  logic              dcache_write_i,
    input  logic              dcache_valid_i,
    output logic [DATA_W-1:0] dcache_rd_data_o,
    output logic              dcache_ready_o,
    // memory master
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wr_data_o,
    output logic              mem_write_o,
    output logic              mem_valid_o,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    input  logic              mem_ready_i,
    // status
    output logic [1:0]        owner_o
);

    // State encoding matches the owner_o code, so owner_o is the state register.
    localparam logic [1:0] c_idle  = 2'b00;
    localparam logic [1:0] c_own_i = 2'b01;
    localparam logic [1:0] c_own_d = 2'b10;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_grant_i;
    logic       w_grant_d;
    logic       w_starve;

    // ------------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------------
`ifdef MEM_BUS_SCHEDULER_ANTI_STARVE_EN
    localparam int              c_cnt_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    logic [c_cnt_w-1:0] r_starve_cnt;

    assign w_starve = (r_starve_cnt == c_limit);

    // Grants are only made in IDLE, so the counter only moves there.
    // An IDLE cycle in which icache is not requesting counts as "not waiting"
    // and clears the count.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_starve_cnt <= '0;
        end else if (r_state == c_idle) begin
            if (w_grant_i || !icache_valid_i) begin
                r_starve_cnt <= '0;
            end else if (w_grant_d && (r_starve_cnt != c_limit)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end
`else
    assign w_starve = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Arbitration (only acted upon in IDLE)
    // ------------------------------------------------------------------------
    assign w_grant_i = icache_valid_i && (!dcache_valid_i || w_starve);
    assign w_grant_d = dcache_valid_i && !w_grant_i;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // While owned, mem_valid_o equals the owner's valid. The FSM leaves the
    // owned state on completion (valid and ready) or on abort (valid dropped).
    // Both cases reduce to (!valid || ready). Otherwise the grant is locked.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (w_grant_i) begin
                    w_state_nxt = c_own_i;
                end else if (w_grant_d) begin
                    w_state_nxt = c_own_d;
                end
            end
            c_own_i: begin
                if (!icache_valid_i || mem_ready_i) begin
                    w_state_nxt = c_idle;
                end
            end
            c_own_d: begin
                if (!dcache_valid_i || mem_ready_i) begin
                    w_state_nxt = c_idle;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Output muxing
    // ------------------------------------------------------------------------
    // mem_ready_i and mem_rd_data_i are only routed to the current owner.
    // In IDLE they are ignored.
    always_comb begin
        mem_addr_o       = '0;
        mem_wr_data_o    = '0;
        mem_write_o      = 1'b0;
        mem_valid_o      = 1'b0;
        icache_ready_o   = 1'b0;
        icache_rd_data_o = '0;
        dcache_ready_o   = 1'b0;
        dcache_rd_data_o = '0;
        case (r_state)
            c_own_i: begin
                mem_addr_o       = icache_addr_i;
                mem_wr_data_o    = icache_wr_data_i;
                mem_write_o      = icache_write_i;
                mem_valid_o      = icache_valid_i;
                icache_ready_o   = mem_ready_i;
                icache_rd_data_o = mem_rd_data_i;
            end
            c_own_d: begin
                mem_addr_o       = dcache_addr_i;
                mem_wr_data_o    = dcache_wr_data_i;
                mem_write_o      = dcache_write_i;
                mem_valid_o      = dcache_valid_i;
                dcache_ready_o   = mem_ready_i;
                dcache_rd_data_o = mem_rd_data_i;
            end
            default: ;
        endcase
    end

    assign owner_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_scheduler
// Purpose  : Self-checking bench for mem_bus_scheduler. Requester drivers pull
//            transactions from per-cache queues. A latency-programmable memory
//            responder returns rd_data = addr ^ RD_XOR. A monitor pops the
//            expected-transaction scoreboard on every memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_scheduler;

    localparam int          ADDR_W       = 32;
    localparam int          DATA_W       = 32;
    localparam int          STARVE_LIMIT = 4;
    localparam logic [31:0] RD_XOR       = 32'hA5A5_0000;
    localparam logic [1:0]  OWN_NONE     = 2'b00;
    localparam logic [1:0]  OWN_I        = 2'b01;
    localparam logic [1:0]  OWN_D        = 2'b10;

    logic              clk_i;
    logic              reset_n_i;
    logic [ADDR_W-1:0] icache_addr_i;
    logic [DATA_W-1:0] icache_wr_data_i;
    logic              icache_write_i;
    logic              icache_valid_i;
    logic [DATA_W-1:0] icache_rd_data_o;
    logic              icache_ready_o;
    logic [ADDR_W-1:0] dcache_addr_i;
    logic [DATA_W-1:0] dcache_wr_data_i;
    logic              dcache_write_i;
    logic              dcache_valid_i;
    logic [DATA_W-1:0] dcache_rd_data_o;
    logic              dcache_ready_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wr_data_o;
    logic              mem_write_o;
    logic              mem_valid_o;
    logic [DATA_W-1:0] mem_rd_data_i;
    logic              mem_ready_i;
    logic [1:0]        owner_o;

    mem_bus_scheduler #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .icache_addr_i    (icache_addr_i),
        .icache_wr_data_i (icache_wr_data_i),
        .icache_write_i   (icache_write_i),
        .icache_valid_i   (icache_valid_i),
        .icache_rd_data_o (icache_rd_data_o),
        .icache_ready_o   (icache_ready_o),
        .dcache_addr_i    (dcache_addr_i),
        .dcache_wr_data_i (dcache_wr_data_i),
        .dcache_write_i   (dcache_write_i),
        .dcache_valid_i   (dcache_valid_i),
        .dcache_rd_data_o (dcache_rd_data_o),
        .dcache_ready_o   (dcache_ready_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wr_data_o    (mem_wr_data_o),
        .mem_write_o      (mem_write_o),
        .mem_valid_o      (mem_valid_o),
        .mem_rd_data_i    (mem_rd_data_i),
        .mem_ready_i      (mem_ready_i),
        .owner_o          (owner_o)
    );

    typedef struct packed {
        logic [1:0]  owner;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
    } txn_t;

    txn_t sb_q[$];
    txn_t i_q[$];
    txn_t d_q[$];

    int n_tests   = 0;
    int n_fail    = 0;
    int mem_lat   = 1;
    int lat_cnt   = 0;
    int i_rdy_cnt = 0;
    bit i_flush   = 1'b0;
    bit d_flush   = 1'b0;
    bit i_hs      = 1'b0;
    bit d_hs      = 1'b0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    assign mem_rd_data_i = mem_addr_o ^ RD_XOR;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_req(input logic [1:0] who, input logic [31:0] a, input logic [31:0] wd,
                            input logic w, input bit exp);
        txn_t t;
        t.owner = who;
        t.addr  = a;
        t.wdata = wd;
        t.write = w;
        if (who == OWN_I) i_q.push_back(t);
        else              d_q.push_back(t);
        if (exp) sb_q.push_back(t);
    endtask

    task automatic exp_txn(input logic [1:0] who, input logic [31:0] a, input logic [31:0] wd,
                           input logic w);
        txn_t t;
        t.owner = who;
        t.addr  = a;
        t.wdata = wd;
        t.write = w;
        sb_q.push_back(t);
    endtask

    task automatic wait_sb_empty(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            @(posedge clk_i);
            n++;
        end
        chk_eq(tag, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        repeat (3) @(negedge clk_i);
    endtask

    task automatic wait_owner(input logic [1:0] who, input int max_cyc, input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk_i);
            #3;
            n++;
        end while (owner_o !== who && n < max_cyc);
        chk_eq(tag, 32'(owner_o), 32'(who));
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(mem_valid_o && mem_ready_i) && n < max_cyc);
        chk_eq(tag, 32'(mem_valid_o && mem_ready_i), 32'd1);
    endtask

    // Memory responder: ready once mem_valid_o has been high for mem_lat cycles.
    initial begin
        mem_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #2;
            if (mem_valid_o) lat_cnt++;
            else             lat_cnt = 0;
            mem_ready_i = mem_valid_o && (lat_cnt >= mem_lat);
        end
    end

    // icache requester
    initial begin : drv_i
        txn_t t;
        icache_valid_i   = 1'b0;
        icache_addr_i    = '0;
        icache_wr_data_i = '0;
        icache_write_i   = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (i_flush) begin
                icache_valid_i = 1'b0;
                i_q.delete();
                i_flush = 1'b0;
            end else begin
                if (icache_valid_i && i_hs) icache_valid_i = 1'b0;
                if (!icache_valid_i && i_q.size() > 0) begin
                    t = i_q.pop_front();
                    icache_addr_i    = t.addr;
                    icache_wr_data_i = t.wdata;
                    icache_write_i   = t.write;
                    icache_valid_i   = 1'b1;
                end
            end
        end
    end

    // dcache requester
    initial begin : drv_d
        txn_t t;
        dcache_valid_i   = 1'b0;
        dcache_addr_i    = '0;
        dcache_wr_data_i = '0;
        dcache_write_i   = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (d_flush) begin
                dcache_valid_i = 1'b0;
                d_q.delete();
                d_flush = 1'b0;
            end else begin
                if (dcache_valid_i && d_hs) dcache_valid_i = 1'b0;
                if (!dcache_valid_i && d_q.size() > 0) begin
                    t = d_q.pop_front();
                    dcache_addr_i    = t.addr;
                    dcache_wr_data_i = t.wdata;
                    dcache_write_i   = t.write;
                    dcache_valid_i   = 1'b1;
                end
            end
        end
    end

    // Handshake monitor / scoreboard checker
    always @(negedge clk_i) begin : mon
        txn_t e;
        if (reset_n_i) begin
            i_hs = icache_valid_i && icache_ready_o;
            d_hs = dcache_valid_i && dcache_ready_o;
            if (icache_ready_o) i_rdy_cnt++;
            if (mem_valid_o && mem_ready_i) begin
                if (sb_q.size() == 0) begin
                    chk_eq("sb_unexpected_txn", 32'(mem_addr_o), 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk_eq("sb_owner", 32'(owner_o), 32'(e.owner));
                    chk_eq("sb_addr", mem_addr_o, e.addr);
                    chk_eq("sb_write", 32'(mem_write_o), 32'(e.write));
                    chk_eq("sb_wdata", mem_wr_data_o, e.wdata);
                    if (e.owner == OWN_I) begin
                        chk_eq("sb_i_ready", 32'(icache_ready_o), 32'd1);
                        chk_eq("sb_i_rdata", icache_rd_data_o, e.addr ^ RD_XOR);
                        chk_eq("sb_d_ready_idle", 32'(dcache_ready_o), 32'd0);
                        chk_eq("sb_d_rdata_idle", dcache_rd_data_o, 32'd0);
                    end else begin
                        chk_eq("sb_d_ready", 32'(dcache_ready_o), 32'd1);
                        chk_eq("sb_d_rdata", dcache_rd_data_o, e.addr ^ RD_XOR);
                        chk_eq("sb_i_ready_idle", 32'(icache_ready_o), 32'd0);
                        chk_eq("sb_i_rdata_idle", icache_rd_data_o, 32'd0);
                    end
                end
            end
        end else begin
            i_hs = 1'b0;
            d_hs = 1'b0;
        end
    end

    initial begin : watchdog
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : main
        int base;
        reset_n_i = 1'b0;

        // Reset state
        #3;
        chk_eq("rst_owner", 32'(owner_o), 32'(OWN_NONE));
        chk_eq("rst_mem_valid", 32'(mem_valid_o), 32'd0);
        chk_eq("rst_mem_addr", mem_addr_o, 32'd0);
        chk_eq("rst_i_ready", 32'(icache_ready_o), 32'd0);
        chk_eq("rst_d_ready", 32'(dcache_ready_o), 32'd0);
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // icache only, addr 0x100, ready after 3 cycles
        mem_lat = 3;
        base    = i_rdy_cnt;
        push_req(OWN_I, 32'h0000_0100, 32'h0, 1'b0, 1'b1);
        @(posedge clk_i); #3;
        chk_eq("t1_arb_cycle_valid", 32'(mem_valid_o), 32'd0);
        chk_eq("t1_arb_cycle_owner", 32'(owner_o), 32'(OWN_NONE));
        @(posedge clk_i); #3;
        chk_eq("t1_grant_valid", 32'(mem_valid_o), 32'd1);
        chk_eq("t1_grant_owner", 32'(owner_o), 32'(OWN_I));
        chk_eq("t1_grant_addr", mem_addr_o, 32'h0000_0100);
        wait_sb_empty(20, "t1_done");
        chk_eq("t1_owner_back", 32'(owner_o), 32'(OWN_NONE));
        chk_eq("t1_i_ready_pulses", 32'(i_rdy_cnt - base), 32'd1);

        // Both valid together: dcache first, bubble, then icache
        mem_lat = 2;
        push_req(OWN_D, 32'h0000_2000, 32'hDEAD_BEEF, 1'b1, 1'b1);
        push_req(OWN_I, 32'h0000_1040, 32'h0, 1'b0, 1'b1);
        wait_done(20, "t2_d_done");
        chk_eq("t2_first_owner", 32'(owner_o), 32'(OWN_D));
        @(negedge clk_i);
        chk_eq("t2_bubble", 32'(owner_o), 32'(OWN_NONE));
        @(negedge clk_i);
        chk_eq("t2_i_grant", 32'(owner_o), 32'(OWN_I));
        wait_sb_empty(20, "t2_done");

        // Grant lock: dcache request during a stalled icache access
        mem_lat = 6;
        push_req(OWN_I, 32'h0000_0300, 32'h0, 1'b0, 1'b1);
        wait_owner(OWN_I, 10, "t3_own_i");
        push_req(OWN_D, 32'h0000_0400, 32'h0000_1234, 1'b1, 1'b1);
        repeat (3) begin
            @(posedge clk_i); #3;
            chk_eq("t3_lock_addr", mem_addr_o, 32'h0000_0300);
            chk_eq("t3_lock_owner", 32'(owner_o), 32'(OWN_I));
        end
        wait_sb_empty(40, "t3_done");

        // Both continuously valid: starvation guard order
        mem_lat = 1;
        for (int k = 0; k < 6; k++)
            push_req(OWN_D, 32'h0000_5000 + 32'(k * 4), 32'(k), 1'b0, 1'b0);
        push_req(OWN_I, 32'h0000_6000, 32'h0, 1'b0, 1'b0);
`ifdef MEM_BUS_SCHEDULER_ANTI_STARVE_EN
        for (int k = 0; k < 4; k++)
            exp_txn(OWN_D, 32'h0000_5000 + 32'(k * 4), 32'(k), 1'b0);
        exp_txn(OWN_I, 32'h0000_6000, 32'h0, 1'b0);
        for (int k = 4; k < 6; k++)
            exp_txn(OWN_D, 32'h0000_5000 + 32'(k * 4), 32'(k), 1'b0);
`else
        for (int k = 0; k < 6; k++)
            exp_txn(OWN_D, 32'h0000_5000 + 32'(k * 4), 32'(k), 1'b0);
        exp_txn(OWN_I, 32'h0000_6000, 32'h0, 1'b0);
`endif
        wait_sb_empty(200, "t4_order");

        // Abort in OWN_D with icache pending
        mem_lat = 1000;
        push_req(OWN_D, 32'h0000_7000, 32'h0, 1'b0, 1'b0);
        wait_owner(OWN_D, 10, "t5_own_d");
        push_req(OWN_I, 32'h0000_7100, 32'h0, 1'b0, 1'b1);
        @(posedge clk_i); #3;
        chk_eq("t5_locked_owner", 32'(owner_o), 32'(OWN_D));
        d_flush = 1'b1;
        @(posedge clk_i); #3;
        chk_eq("t5_abort_valid", 32'(mem_valid_o), 32'd0);
        chk_eq("t5_abort_owner", 32'(owner_o), 32'(OWN_D));
        @(posedge clk_i); #3;
        chk_eq("t5_idle", 32'(owner_o), 32'(OWN_NONE));
        mem_lat = 2;
        @(posedge clk_i); #3;
        chk_eq("t5_i_grant", 32'(owner_o), 32'(OWN_I));
        chk_eq("t5_i_valid", 32'(mem_valid_o), 32'd1);
        wait_sb_empty(20, "t5_done");

        // Asynchronous reset during OWN_D with memory ready
        mem_lat = 1;
        push_req(OWN_D, 32'h0000_8000, 32'h0000_0055, 1'b1, 1'b0);
        wait_owner(OWN_D, 10, "t6_own_d");
        chk_eq("t6_pre_ready", 32'(dcache_ready_o), 32'd1);
        #0.5;
        reset_n_i = 1'b0;
        #0.5;
        chk_eq("t6_rst_valid", 32'(mem_valid_o), 32'd0);
        chk_eq("t6_rst_d_ready", 32'(dcache_ready_o), 32'd0);
        chk_eq("t6_rst_owner", 32'(owner_o), 32'(OWN_NONE));
        chk_eq("t6_rst_addr", mem_addr_o, 32'd0);
        chk_eq("t6_rst_d_rdata", dcache_rd_data_o, 32'd0);
        d_flush = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk_eq("t6_post_owner", 32'(owner_o), 32'(OWN_NONE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
